// File: rtl/inst_fetch.sv
// MIPS instruction-fetch stage: owns the PC, reads the instruction bus with req/ack and feeds IF/ID.
// Outputs are combinational from state and bus inputs; a flushed in-flight read is drained in DROP.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    input  logic        flush,
    input  logic [31:0] new_pc,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_ack,
    input  logic [31:0] ibus_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_if
);

    typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] req_addr, req_addr_nxt;
    logic [31:0] hold_inst, hold_inst_nxt;
    logic [31:0] seq_pc;
    logic        valid;
    logic        handoff;
    logic        unused_stall;

    assign unused_stall = ^stall[5:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            hold_inst <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            req_addr  <= req_addr_nxt;
            hold_inst <= hold_inst_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        req_addr_nxt  = req_addr;
        hold_inst_nxt = hold_inst;
        valid         = ((state == FETCH) && ibus_ack) || (state == HOLD);
        handoff       = valid && !stall[0] && !flush;
        // The instruction handed off alongside branch_flag is the delay slot.
        seq_pc        = branch_flag ? branch_target : pc + 32'd4;

        unique case (state)
            FETCH: begin
                req_addr_nxt = pc;
                if (flush) begin
                    pc_nxt = new_pc;
                    if (!ibus_ack)
                        state_nxt = DROP;
                end else if (handoff) begin
                    pc_nxt = seq_pc;
                end else if (ibus_ack) begin
                    hold_inst_nxt = ibus_rdata;
                    state_nxt     = HOLD;
                end
            end
            HOLD: begin
                if (flush) begin
                    pc_nxt    = new_pc;
                    state_nxt = FETCH;
                end else if (handoff) begin
                    pc_nxt    = seq_pc;
                    state_nxt = FETCH;
                end
            end
            DROP: begin
                // The old request stays on the bus until acked; its data is thrown away.
                if (flush)
                    pc_nxt = new_pc;
                if (ibus_ack)
                    state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        ibus_req    = (state != HOLD);
        ibus_addr   = (state == DROP) ? req_addr : pc;
        if_pc       = '0;
        if_inst     = '0;
        stallreq_if = 1'b1;
        if (valid && !flush) begin
            if_pc       = pc;
            if_inst     = (state == FETCH) ? ibus_rdata : hold_inst;
            stallreq_if = 1'b0;
        end
        if (rst) begin
            ibus_req    = 1'b0;
            ibus_addr   = '0;
            if_pc       = '0;
            if_inst     = '0;
            stallreq_if = 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed cycle table followed by a randomised zero/multi-wait fetch run.
module tb_inst_fetch;

    localparam logic [31:0] K = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        flush;
    logic [31:0] new_pc;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ack;
    logic [31:0] ibus_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_if;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .flush(flush), .new_pc(new_pc),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr),
        .ibus_ack(ibus_ack), .ibus_rdata(ibus_rdata),
        .if_pc(if_pc), .if_inst(if_inst), .stallreq_if(stallreq_if)
    );

    typedef struct {
        logic        rst, st, ack, fl, br;
        logic [31:0] npc, tgt;
        logic        ereq;
        logic [31:0] eaddr, epc, einst;
        logic        estl;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t v(logic r, logic s, logic a, logic f, logic b,
                               logic [31:0] np, logic [31:0] tg,
                               logic er, logic [31:0] ea, logic [31:0] ep, logic el);
        vec_t x;
        x.rst = r; x.st = s; x.ack = a; x.fl = f; x.br = b; x.npc = np; x.tgt = tg;
        x.ereq = er; x.eaddr = ea; x.epc = ep;
        // A presented instruction is always memory data for its PC; nothing presented means NOP.
        x.einst = el ? 32'h0 : ((er || ep != 32'h0 || !r) ? (ep ^ K) : 32'h0);
        if (el || r) x.einst = 32'h0;
        x.estl = el;
        return x;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s step %0d: got %h want %h", name, idx, act, want);
    endtask

    task automatic drive(vec_t x);
        @(negedge clk);
        rst           = x.rst;
        stall         = {5'b0, x.st};
        ibus_ack      = x.ack;
        ibus_rdata    = x.eaddr ^ K;
        flush         = x.fl;
        new_pc        = x.npc;
        branch_flag   = x.br;
        branch_target = x.tgt;
        exp_q.push_back(x);
    endtask

    task automatic check(int idx);
        vec_t e;
        #1;
        e = exp_q.pop_front();
        chk("ibus_req", idx, {31'b0, ibus_req}, {31'b0, e.ereq});
        if (e.ereq) chk("ibus_addr", idx, ibus_addr, e.eaddr);
        if (e.rst)  chk("ibus_addr_rst", idx, ibus_addr, 32'h0);
        chk("if_pc", idx, if_pc, e.epc);
        chk("if_inst", idx, if_inst, e.einst);
        chk("stallreq_if", idx, {31'b0, stallreq_if}, {31'b0, e.estl});
    endtask

    initial begin : main
        logic [31:0] pc_m;
        logic        a, b;
        logic [31:0] t;
        vec_t        x;

        rst = 1'b1; stall = '0; ibus_ack = 0; ibus_rdata = '0;
        flush = 0; new_pc = '0; branch_flag = 0; branch_target = '0;

        //        rst st ack fl br  new_pc        target        req addr          if_pc         stl
        tbl.push_back(v(1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        0));
        tbl.push_back(v(1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        0));
        tbl.push_back(v(0, 0, 1, 0, 0, 32'h0,        32'h0,        1, 32'hBFC00000, 32'hBFC00000, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 32'h0,        32'h0,        1, 32'hBFC00004, 32'hBFC00004, 0));
        tbl.push_back(v(0, 0, 1, 0, 1, 32'h0,        32'hBFC00100, 1, 32'hBFC00008, 32'hBFC00008, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 32'hBFC00100, 32'h0,        1));
        tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 32'hBFC00100, 32'h0,        1));
        tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 32'hBFC00100, 32'h0,        1));
        tbl.push_back(v(0, 0, 1, 0, 0, 32'h0,        32'h0,        1, 32'hBFC00100, 32'hBFC00100, 0));
        tbl.push_back(v(0, 1, 1, 0, 0, 32'h0,        32'h0,        1, 32'hBFC00104, 32'hBFC00104, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        32'hBFC00104, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        32'hBFC00104, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        32'hBFC00104, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 32'h0,        32'h0,        1, 32'hBFC00108, 32'hBFC00108, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 32'h0,        32'h0,        1, 32'hBFC0010C, 32'hBFC0010C, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 32'hBFC00380, 32'h0,        1, 32'hBFC00110, 32'h0,        1));
        tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 32'hBFC00110, 32'h0,        1));
        tbl.push_back(v(0, 0, 1, 0, 0, 32'h0,        32'h0,        1, 32'hBFC00110, 32'h0,        1));
        tbl.push_back(v(0, 0, 1, 0, 0, 32'h0,        32'h0,        1, 32'hBFC00380, 32'hBFC00380, 0));
        tbl.push_back(v(0, 0, 1, 1, 0, 32'hBFC00400, 32'h0,        1, 32'hBFC00384, 32'h0,        1));
        tbl.push_back(v(0, 0, 1, 0, 0, 32'h0,        32'h0,        1, 32'hBFC00400, 32'hBFC00400, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 32'hBFC00404, 32'h0,        1));
        tbl.push_back(v(1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        0));
        tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 32'hBFC00000, 32'h0,        1));
        tbl.push_back(v(0, 0, 1, 0, 0, 32'h0,        32'h0,        1, 32'hBFC00000, 32'hBFC00000, 0));
        tbl.push_back(v(0, 1, 1, 0, 0, 32'h0,        32'h0,        1, 32'hBFC00004, 32'hBFC00004, 0));
        tbl.push_back(v(0, 1, 0, 1, 0, 32'hBFC00500, 32'h0,        0, 32'h0,        32'h0,        1));
        tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 32'hBFC00500, 32'h0,        1));
        tbl.push_back(v(0, 0, 0, 1, 0, 32'hBFC00600, 32'h0,        1, 32'hBFC00500, 32'h0,        1));
        tbl.push_back(v(0, 0, 0, 1, 0, 32'hBFC00700, 32'h0,        1, 32'hBFC00500, 32'h0,        1));
        tbl.push_back(v(0, 0, 1, 0, 0, 32'h0,        32'h0,        1, 32'hBFC00500, 32'h0,        1));
        tbl.push_back(v(0, 0, 1, 0, 0, 32'h0,        32'h0,        1, 32'hBFC00700, 32'hBFC00700, 0));
        tbl.push_back(v(0, 0, 1, 1, 0, 32'hFFFFFFFC, 32'h0,        1, 32'hBFC00704, 32'h0,        1));
        tbl.push_back(v(0, 0, 1, 0, 0, 32'h0,        32'h0,        1, 32'hFFFFFFFC, 32'hFFFFFFFC, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 32'h0,        32'h0,        1, 32'h00000000, 32'h00000000, 0));

        foreach (tbl[i]) begin
            drive(tbl[i]);
            check(i);
        end

        // Random wait states and branches; the model only tracks the fetch PC.
        pc_m = 32'h4;
        for (int i = 0; i < 60; i++) begin
            a = 1'($urandom_range(0, 1));
            b = a && ($urandom_range(0, 3) == 0);
            t = {$urandom_range(0, 32'hFFFF), 2'b00} | 32'h8000_0000;
            x = v(0, 0, a, 0, b, 32'h0, t, 1, pc_m, a ? pc_m : 32'h0, !a);
            x.einst = a ? (pc_m ^ K) : 32'h0;
            drive(x);
            check(100 + i);
            if (a) pc_m = b ? t : pc_m + 32'd4;
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
